// File: rtl/ascii_to_binary_pkg.sv
// Shared definitions for the ASCII-decimal parser: character codes,
// FSM state encoding and the result-width helper used by the ASCII
// display converter as well.
package ascii_to_binary_pkg;

  // ASCII character codes recognised by the parser
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_NINE  = 8'h39;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  // Parser FSM state encoding
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACCUM   = 2'd1;
  localparam logic [1:0] ST_DISCARD = 2'd2;

  // Binary result width: four bits per nibble
  function automatic int unsigned result_width(input int unsigned nibble_size);
    return 32'd4 * nibble_size;
  endfunction

endpackage

// File: rtl/ascii_to_binary_classify.sv
// Combinational character classifier: flags decimal digits and number
// terminators and extracts the digit value.
module ascii_digit_classify
  import ascii_to_binary_pkg::*;
(
  input  logic [7:0] char_in,
  output logic       is_digit,
  output logic       is_term,
  output logic [3:0] digit_val
);

  // The low nibble of '0'..'9' is the digit value itself
  assign is_digit  = (char_in >= ASCII_ZERO) && (char_in <= ASCII_NINE);
  assign is_term   = (char_in == ASCII_CR) || (char_in == ASCII_SPACE);
  assign digit_val = is_digit ? char_in[3:0] : 4'h0;

endmodule

// File: rtl/ascii_to_binary.sv
// Serial ASCII-decimal to binary parser. Digits are accumulated with a
// x10 shift-add; a CR or space terminator emits the value, a stray
// character rejects the number and skips to the next terminator.
module ascii_to_binary
  import ascii_to_binary_pkg::*;
#(
  parameter  int unsigned NIBBLE_SIZE = 3,
  localparam int unsigned W           = result_width(NIBBLE_SIZE)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  input  logic         char_valid,
  input  logic [7:0]   char_in,
  output logic [W-1:0] binary_out,
  output logic         out_valid,
  output logic         error,
  output logic         busy
);

  // Accumulator has four spare bits so acc*10+9 never wraps while acc <= 2^W
  localparam int unsigned AW = W + 4;
  localparam logic [AW-1:0] MAX_VAL   = {4'b0000, {W{1'b1}}};
  localparam logic [AW-1:0] CLAMP_VAL = {3'b000, 1'b1, {W{1'b0}}};

  logic          is_digit_s;
  logic          is_term_s;
  logic [3:0]    digit_val_s;

  logic [1:0]    state_r;
  logic [1:0]    state_nxt_s;
  logic [AW-1:0] acc_r;
  logic [AW-1:0] acc_nxt_s;
  logic [AW-1:0] acc_x10_s;
  logic          ovf_r;
  logic          ovf_nxt_s;
  logic [W-1:0]  binary_out_r;
  logic [W-1:0]  out_nxt_s;
  logic          out_valid_r;
  logic          valid_nxt_s;
  logic          error_r;
  logic          error_nxt_s;
  logic          busy_r;

  ascii_digit_classify u_classify (
    .char_in   (char_in),
    .is_digit  (is_digit_s),
    .is_term   (is_term_s),
    .digit_val (digit_val_s)
  );

  // acc*10 + d as (acc<<3) + (acc<<1) + d
  assign acc_x10_s = {acc_r[AW-4:0], 3'b000}
                   + {acc_r[AW-2:0], 1'b0}
                   + {{(AW-4){1'b0}}, digit_val_s};

  // Next-state, accumulator and output-pulse decode
  always_comb begin
    state_nxt_s = state_r;
    acc_nxt_s   = acc_r;
    ovf_nxt_s   = ovf_r;
    out_nxt_s   = binary_out_r;
    valid_nxt_s = 1'b0;
    error_nxt_s = 1'b0;
    if (!enable) begin
      // Disabled: abandon any number silently, binary_out holds
      state_nxt_s = ST_IDLE;
      acc_nxt_s   = {AW{1'b0}};
      ovf_nxt_s   = 1'b0;
    end else if (char_valid) begin
      case (state_r)
        ST_IDLE: begin
          if (is_digit_s) begin
            acc_nxt_s   = {{(AW-4){1'b0}}, digit_val_s};
            ovf_nxt_s   = 1'b0;
            state_nxt_s = ST_ACCUM;
          end else if (is_term_s) begin
            // Empty number: nothing to report
            state_nxt_s = ST_IDLE;
          end else begin
            error_nxt_s = 1'b1;
            state_nxt_s = ST_DISCARD;
          end
        end
        ST_ACCUM: begin
          if (is_digit_s) begin
            if (ovf_r || (acc_x10_s > MAX_VAL)) begin
              // Clamp so further digits cannot wrap back into range
              ovf_nxt_s = 1'b1;
              acc_nxt_s = CLAMP_VAL;
            end else begin
              acc_nxt_s = acc_x10_s;
            end
          end else if (is_term_s) begin
            if (ovf_r) begin
              error_nxt_s = 1'b1;
            end else begin
              out_nxt_s   = acc_r[W-1:0];
              valid_nxt_s = 1'b1;
            end
            acc_nxt_s   = {AW{1'b0}};
            ovf_nxt_s   = 1'b0;
            state_nxt_s = ST_IDLE;
          end else begin
            error_nxt_s = 1'b1;
            state_nxt_s = ST_DISCARD;
          end
        end
        ST_DISCARD: begin
          // Swallow the rest of a rejected number without further errors
          if (is_term_s) begin
            acc_nxt_s   = {AW{1'b0}};
            ovf_nxt_s   = 1'b0;
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_DISCARD;
          end
        end
        default: begin
          acc_nxt_s   = {AW{1'b0}};
          ovf_nxt_s   = 1'b0;
          state_nxt_s = ST_IDLE;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // State, accumulator and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      acc_r        <= {AW{1'b0}};
      ovf_r        <= 1'b0;
      binary_out_r <= {W{1'b0}};
      out_valid_r  <= 1'b0;
      error_r      <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      acc_r        <= acc_nxt_s;
      ovf_r        <= ovf_nxt_s;
      binary_out_r <= out_nxt_s;
      out_valid_r  <= valid_nxt_s;
      error_r      <= error_nxt_s;
      busy_r       <= (state_nxt_s != ST_IDLE);
    end
  end

  assign binary_out = binary_out_r;
  assign out_valid  = out_valid_r;
  assign error      = error_r;
  assign busy       = busy_r;

endmodule
